jk_checker: RTL
===============

Name: jk_checker

Overview:
- Self-checking response monitor for the FJKRSE JK flip-flop. It is the reading end of the JK stimulus interface.
- It samples the same J/K/R/S/CE inputs the bench drives, and carries a cycle-accurate reference model of the flip-flop.
- Each cycle it compares the model against the DUT's Qout, then reports mismatches, counts and first-failure time.
- It sits beside the UUT in benches and in on-board self-test, so benches no longer rely on reading $monitor output by eye.

Parameters:
- INIT, 1'b0, model value loaded at checker reset when START_SYNCED=1.
- START_SYNCED, 0: 1 means compare immediately after reset; 0 means wait for a DUT set or reset before comparing.
- ERR_W, 8, width of ErrCnt (saturating).
- CYC_W, 16, width of CycCnt, ChkCnt and FirstFail (saturating).

Ports:
- Clk  in  1  checker and DUT clock.
- R  in  1  checker reset (synchronous, active-high); independent of the DUT's R.
- DutJ  in  1  J as driven to the DUT.
- DutK  in  1  K as driven to the DUT.
- DutR  in  1  DUT synchronous reset as driven.
- DutS  in  1  DUT synchronous set as driven.
- DutCE  in  1  DUT clock enable as driven.
- Qout  in  1  DUT output under check.
- Clr  in  1  clear statistics; the model and state are kept.
- Qexp  out  1  model's expected Q.
- Synced  out  1  high in state TRACK.
- Mismatch  out  1  one-cycle pulse on a failed compare.
- ErrFlag  out  1  sticky failure flag.
- ErrCnt  out  ERR_W  failed compares.
- ChkCnt  out  CYC_W  compares performed.
- CycCnt  out  CYC_W  cycles since reset or Clr.
- FirstFail  out  CYC_W  CycCnt value at the first failure.

Behaviour:
- Interface: one clock, Clk. Reset R is synchronous and active-high. Everything is updated on the posedge of Clk only.
- Reset values:
  - Qexp=INIT.
  - State = TRACK if START_SYNCED=1, otherwise UNSYNC.
  - Mismatch=0, ErrFlag=0, ErrCnt=0, ChkCnt=0, CycCnt=0, FirstFail=0.
  - R overrides every other input, including Clr.
- Model next state (FJKRSE priority), evaluated from inputs sampled at the edge:
  - DutR=1 -> 0.
  - else DutS=1 -> 1.
  - else DutCE=0 -> hold.
  - else JK=00 hold, 01 -> 0, 10 -> 1, 11 -> toggle.
- State UNSYNC (model value unknown):
  - No compares are made.
  - DutR or DutS sampled high -> Qexp gets the forced value and the state moves to TRACK.
  - Otherwise Qexp holds.
- State TRACK, at each edge:
  - First compare Qout against the current Qexp (both reflect the previous edge). Then load Qexp with the model next state.
  - ChkCnt increments on every compare.
- Failed compare:
  - Qout≠Qexp; in simulation, any X or Z on Qout also counts as a failure.
  - Effects: Mismatch=1 in the following cycle (latency 1); ErrFlag gets 1; ErrCnt increments.
  - On the first failure after reset or Clr, FirstFail gets the current CycCnt.
- Continuing after a failure: the model keeps its own value and does not resync to Qout, so one DUT error keeps flagging until a DUT R or S realigns it.
- CycCnt increments every cycle in both states.
- Saturation: all counters saturate at all-ones and never wrap.
- Clr=1:
  - CycCnt, ChkCnt, ErrCnt, FirstFail, ErrFlag and Mismatch all go to 0.
  - That cycle's compare is discarded.
  - The model update and the state update still happen.
  - Clr on the same edge as a failure -> ErrCnt=0 and ErrFlag=0.
- DutR and DutS high together: reset wins, Qexp=0.

Decomposition:
- Shared package jk_pkg:
  - state enum UNSYNC=1'b0, TRACK=1'b1;
  - JK code constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11;
  - function jk_next(q,j,k,r,s,ce), reusable by other models.
- One natural sub-module: jk_model_ff, the registered reference flip-flop holding Qexp with INIT.
- Compare, statistics and state logic stay in jk_checker.

Test Plan:
1. START_SYNCED=0, reset, then DutR=1 for 2 cycles with Qout following a correct FJKRSE -> Synced=1 after the first DutR edge; ErrCnt=0; ChkCnt=1 after the second edge.
2. Full sequence at 20 ns period, correct DUT: R 50 ns, S 50 ns, JK=11 with CE=0, then CE=1 through JK=00,01,10,11 at 50 ns each -> ErrFlag=0, ErrCnt=0; Qexp toggles every cycle during CE=1, JK=11.
3. DUT with J and K swapped, CE=1, JK=10 from Q=0 -> Mismatch pulses the cycle after the second edge; ErrCnt=1; FirstFail equals that edge's CycCnt; ErrCnt keeps climbing until DutR realigns the model.
4. DutR=DutS=1 together -> Qexp=0; a DUT reporting 1 gives ErrCnt+1.
5. ERR_W=2 with a stuck-at-1 Qout against model 0 for 6 cycles -> ErrCnt saturates at 3; Clr pulse -> all statistics 0 the next cycle, while Qexp and Synced are unchanged.
6. Checker R asserted mid-TRACK with errors pending -> the next cycle shows all outputs at reset values and the state is UNSYNC; compares resume only after the next DutR or DutS.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the FJKRSE next-state rule for the JK checker and any other JK models.
package jk_pkg;

    typedef enum logic {
        UNSYNC = 1'b0,
        TRACK  = 1'b1
    } chk_state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Reset beats set, set beats clock enable, then the JK code decides.
    function automatic logic jk_next(input logic q, input logic j, input logic k,
                                     input logic r, input logic s, input logic ce);
        logic n;
        n = q;
        if (r)
            n = 1'b0;
        else if (s)
            n = 1'b1;
        else if (ce) begin
            case ({j, k})
                JK_HOLD: n = q;
                JK_RST:  n = 1'b0;
                JK_SET:  n = 1'b1;
                JK_TOG:  n = ~q;
                default: n = q;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/jk_model_ff.sv
// Registered reference flip-flop holding the checker's expected Q.
module jk_model_ff #(
    parameter logic INIT = 1'b0
) (
    input  logic Clk,
    input  logic R,
    input  logic Ld,
    input  logic D,
    output logic Q
);

    always_ff @(posedge Clk) begin
        if (R)
            Q <= INIT;
        else if (Ld)
            Q <= D;
    end

endmodule

// File: rtl/jk_checker.sv
// Response monitor for the FJKRSE flip-flop: tracks a reference model and keeps error statistics.
module jk_checker
    import jk_pkg::*;
#(
    parameter logic INIT         = 1'b0,
    parameter int   START_SYNCED = 0,
    parameter int   ERR_W        = 8,
    parameter int   CYC_W        = 16
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             DutJ,
    input  logic             DutK,
    input  logic             DutR,
    input  logic             DutS,
    input  logic             DutCE,
    input  logic             Qout,
    input  logic             Clr,
    output logic             Qexp,
    output logic             Synced,
    output logic             Mismatch,
    output logic             ErrFlag,
    output logic [ERR_W-1:0] ErrCnt,
    output logic [CYC_W-1:0] ChkCnt,
    output logic [CYC_W-1:0] CycCnt,
    output logic [CYC_W-1:0] FirstFail
);

    // state  | meaning
    // UNSYNC | model value unknown, waiting for a DUT reset or set
    // TRACK  | model aligned, compare every edge

    localparam chk_state_t RST_STATE = (START_SYNCED != 0) ? TRACK : UNSYNC;

    chk_state_t state, state_nxt;
    logic       model_ld;
    logic       model_d;
    logic       fail;
    logic       chk_fail;

    always_ff @(posedge Clk) begin
        if (R)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNSYNC:  if (DutR || DutS) state_nxt = TRACK;
            TRACK:   state_nxt = TRACK;
            default: state_nxt = RST_STATE;
        endcase
    end

    // While unsynced only a forced value is loaded; jk_next yields it when R or S is high.
    assign model_ld = (state == TRACK) || DutR || DutS;
    assign model_d  = jk_next(Qexp, DutJ, DutK, DutR, DutS, DutCE);

    jk_model_ff #(
        .INIT (INIT)
    ) u_model (
        .Clk (Clk),
        .R   (R),
        .Ld  (model_ld),
        .D   (model_d),
        .Q   (Qexp)
    );

    // Case inequality so an X or Z on Qout is treated as a failure in simulation.
    assign fail     = (Qout !== Qexp);
    assign chk_fail = (state == TRACK) && fail;
    assign Synced   = (state == TRACK);

    always_ff @(posedge Clk) begin
        if (R || Clr) begin
            Mismatch  <= 1'b0;
            ErrFlag   <= 1'b0;
            ErrCnt    <= '0;
            ChkCnt    <= '0;
            CycCnt    <= '0;
            FirstFail <= '0;
        end else begin
            if (CycCnt != {CYC_W{1'b1}})
                CycCnt <= CycCnt + CYC_W'(1);
            if ((state == TRACK) && (ChkCnt != {CYC_W{1'b1}}))
                ChkCnt <= ChkCnt + CYC_W'(1);
            Mismatch <= chk_fail;
            if (chk_fail) begin
                ErrFlag <= 1'b1;
                if (ErrCnt != {ERR_W{1'b1}})
                    ErrCnt <= ErrCnt + ERR_W'(1);
                if (!ErrFlag)
                    FirstFail <= CycCnt;
            end
        end
    end

endmodule
